// File: rtl/mem_io_responder_if.sv
// Byte-wide external memory bus between the CPU memory controller (master)
// and the memory/IO responder (slave).
interface mem_io_responder_if;
  logic [31:0] mem_a;
  logic [7:0]  mem_dout;
  logic        mem_wr;
  logic [7:0]  mem_din;
  logic        rdy;

  modport master (
    output mem_a,
    output mem_dout,
    output mem_wr,
    input  mem_din,
    input  rdy
  );

  modport slave (
    input  mem_a,
    input  mem_dout,
    input  mem_wr,
    output mem_din,
    output rdy
  );
endinterface

// File: rtl/mem_io_responder.sv
// Byte RAM plus console (RX/TX FIFO) data port and status/halt port on the
// controller's external bus; one-cycle read latency, stalls via rdy.
module mem_io_responder #(
  parameter int unsigned ADDR_WIDTH = 17,
  parameter int unsigned FIFO_DEPTH = 8,
  parameter logic [31:0] IO_BASE    = 32'h30000
) (
  input  logic                     clk,
  input  logic                     rst,
  mem_io_responder_if.slave        bus,
  output logic [7:0]               tx_data,
  output logic                     tx_valid,
  input  logic                     tx_ready,
  input  logic [7:0]               rx_data,
  input  logic                     rx_valid,
  output logic                     rx_ready,
  output logic                     halt
);

  localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
  localparam int unsigned CntW = PtrW + 1;
  localparam logic [CntW-1:0] FullCnt  = CntW'(FIFO_DEPTH);
  localparam logic [31:0]     StatAddr = IO_BASE + 32'd4;

  logic [7:0] ram     [2**ADDR_WIDTH];
  logic [7:0] rx_mem  [FIFO_DEPTH];
  logic [7:0] tx_mem  [FIFO_DEPTH];

  logic [PtrW-1:0] rx_wptr_q, rx_rptr_q, tx_wptr_q, tx_rptr_q;
  logic [CntW-1:0] rx_cnt_q, tx_cnt_q;
  logic [7:0]      mem_din_q;
  logic            halt_q;

  logic [ADDR_WIDTH-1:0] idx;
  logic is_data, is_stat, is_ram;
  logic rx_empty, rx_full, tx_empty, tx_full;
  logic rdy, acc_ok;
  logic rx_push, rx_pop, tx_push, tx_pop;
  logic ram_we, ram_rd, stat_rd, stat_wr;

  always_comb begin
    idx      = bus.mem_a[ADDR_WIDTH-1:0];
    is_data  = (bus.mem_a == IO_BASE);
    is_stat  = (bus.mem_a == StatAddr);
    is_ram   = !is_data && !is_stat;
    rx_empty = (rx_cnt_q == '0);
    rx_full  = (rx_cnt_q == FullCnt);
    tx_empty = (tx_cnt_q == '0);
    tx_full  = (tx_cnt_q == FullCnt);
    rdy      = !(is_data && !bus.mem_wr && rx_empty) && !(is_data && bus.mem_wr && tx_full);
    // Nothing on the bus takes effect while stalled or in the reset cycle.
    acc_ok   = rdy && !rst;
    rx_pop   = acc_ok && is_data && !bus.mem_wr;
    tx_push  = acc_ok && is_data && bus.mem_wr;
    stat_rd  = acc_ok && is_stat && !bus.mem_wr;
    stat_wr  = acc_ok && is_stat && bus.mem_wr;
    ram_we   = acc_ok && is_ram && bus.mem_wr;
    ram_rd   = acc_ok && is_ram && !bus.mem_wr;
    rx_push  = rx_valid && !rx_full;
    tx_pop   = !tx_empty && tx_ready;
  end

  assign bus.rdy     = rdy;
  assign bus.mem_din = mem_din_q;
  assign tx_data     = tx_mem[tx_rptr_q];
  assign tx_valid    = !tx_empty;
  assign rx_ready    = !rx_full;
  assign halt        = halt_q;

  // Storage arrays carry no reset; pointers and counts define their contents.
  always_ff @(posedge clk) begin
    if (ram_we) begin
      ram[idx] <= bus.mem_dout;
    end
    if (rx_push) begin
      rx_mem[rx_wptr_q] <= rx_data;
    end
    if (tx_push) begin
      tx_mem[tx_wptr_q] <= bus.mem_dout;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_wptr_q <= '0;
      rx_rptr_q <= '0;
      tx_wptr_q <= '0;
      tx_rptr_q <= '0;
      rx_cnt_q  <= '0;
      tx_cnt_q  <= '0;
      mem_din_q <= '0;
      halt_q    <= 1'b0;
    end else begin
      if (rx_push) rx_wptr_q <= rx_wptr_q + PtrW'(1);
      if (rx_pop)  rx_rptr_q <= rx_rptr_q + PtrW'(1);
      if (tx_push) tx_wptr_q <= tx_wptr_q + PtrW'(1);
      if (tx_pop)  tx_rptr_q <= tx_rptr_q + PtrW'(1);
      rx_cnt_q <= rx_cnt_q + CntW'(rx_push) - CntW'(rx_pop);
      tx_cnt_q <= tx_cnt_q + CntW'(tx_push) - CntW'(tx_pop);

      if (rx_pop) begin
        mem_din_q <= rx_mem[rx_rptr_q];
      end else if (stat_rd) begin
        mem_din_q <= {6'b0, tx_full, !rx_empty};
      end else if (ram_rd) begin
        mem_din_q <= ram[idx];
      end

      if (stat_wr) halt_q <= 1'b1;
    end
  end

endmodule

// File: tb/tb_mem_io_responder.sv
// Directed self-checking bench for mem_io_responder: RAM, TX/RX FIFOs,
// stalls, status/halt and mid-operation reset.
module tb_mem_io_responder;

  localparam logic [31:0] DataA = 32'h30000;
  localparam logic [31:0] StatA = 32'h30004;

  logic       clk;
  logic       rst;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready;
  logic       halt;

  int checks = 0;
  int errors = 0;

  mem_io_responder_if bus ();

  mem_io_responder dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus),
    .tx_data  (tx_data),
    .tx_valid (tx_valid),
    .tx_ready (tx_ready),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .rx_ready (rx_ready),
    .halt     (halt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic bus_set(input logic [31:0] a, input logic w, input logic [7:0] d);
    bus.mem_a    = a;
    bus.mem_wr   = w;
    bus.mem_dout = d;
  endtask

  task automatic idle();
    bus_set(StatA, 1'b0, 8'h00);
  endtask

  initial begin
    rst      = 1'b1;
    tx_ready = 1'b0;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    idle();
    cyc();
    cyc();
    check("rst_mem_din", bus.mem_din, 8'h00);
    check("rst_halt", halt, 1'b0);
    check("rst_tx_valid", tx_valid, 1'b0);
    check("rst_rx_ready", rx_ready, 1'b1);
    bus_set(DataA, 1'b0, 8'h00);
    #1 check("rst_rdy_data_rd", bus.rdy, 1'b0);
    bus_set(DataA, 1'b1, 8'h00);
    #1 check("rst_rdy_data_wr", bus.rdy, 1'b1);
    idle();
    rst = 1'b0;
    cyc();
    check("idle_stat", bus.mem_din, 8'h00);

    // RAM writes, back-to-back reads, alias, write-hold, write-then-read
    bus_set(32'h10, 1'b1, 8'hA5); cyc();
    bus_set(32'h11, 1'b1, 8'h3C); cyc();
    bus_set(32'h10, 1'b0, 8'h00); cyc();
    check("ram_rd_10", bus.mem_din, 8'hA5);
    bus_set(32'h11, 1'b0, 8'h00); cyc();
    check("ram_rd_11", bus.mem_din, 8'h3C);
    bus_set(32'h20010, 1'b0, 8'h00); cyc();
    check("ram_alias", bus.mem_din, 8'hA5);
    bus_set(32'h13, 1'b1, 8'hEE); cyc();
    check("ram_wr_hold", bus.mem_din, 8'hA5);
    bus_set(32'h13, 1'b0, 8'h00); cyc();
    check("ram_wr_then_rd", bus.mem_din, 8'hEE);
    idle(); cyc();

    // TX backpressure
    for (int i = 1; i <= 8; i++) begin
      bus_set(DataA, 1'b1, 8'(i));
      #1 check("tx_wr_rdy", bus.rdy, 1'b1);
      cyc();
    end
    bus_set(DataA, 1'b1, 8'd9);
    #1 check("tx_full_rdy", bus.rdy, 1'b0);
    check("tx_full_valid", tx_valid, 1'b1);
    check("tx_head_1", tx_data, 8'd1);
    cyc();
    tx_ready = 1'b1;
    #1 check("tx_stall_still", bus.rdy, 1'b0);
    check("tx_head_1b", tx_data, 8'd1);
    cyc();
    check("tx_stall_clear", bus.rdy, 1'b1);
    check("tx_head_2", tx_data, 8'd2);
    cyc();
    idle();
    for (int e = 3; e <= 9; e++) begin
      check("tx_seq_valid", tx_valid, 1'b1);
      check("tx_seq_data", tx_data, 32'(e));
      cyc();
    end
    check("tx_drained", tx_valid, 1'b0);
    tx_ready = 1'b0;

    // RX stall
    bus_set(DataA, 1'b0, 8'h00);
    #1 check("rx_stall_rdy", bus.rdy, 1'b0);
    for (int k = 0; k < 5; k++) begin
      cyc();
      check("rx_stall_hold", bus.rdy, 1'b0);
    end
    check("rx_stall_din", bus.mem_din, 8'h00);
    rx_valid = 1'b1;
    rx_data  = 8'h41;
    cyc();
    rx_valid = 1'b0;
    check("rx_stall_release", bus.rdy, 1'b1);
    check("rx_din_before", bus.mem_din, 8'h00);
    cyc();
    check("rx_din_41", bus.mem_din, 8'h41);
    idle(); cyc();
    check("rx_empty_stat", bus.mem_din, 8'h00);
    check("rx_ready_after", rx_ready, 1'b1);

    // Status and halt
    rx_valid = 1'b1;
    rx_data  = 8'h55;
    bus_set(DataA, 1'b1, 8'h10); cyc();
    rx_valid = 1'b0;
    for (int i = 1; i < 8; i++) begin
      bus_set(DataA, 1'b1, 8'(8'h10 + i)); cyc();
    end
    bus_set(StatA, 1'b0, 8'h00); cyc();
    check("stat_03", bus.mem_din, 8'h03);
    bus_set(StatA, 1'b1, 8'h00); cyc();
    check("halt_set", halt, 1'b1);
    idle();
    repeat (10) cyc();
    check("halt_sticky", halt, 1'b1);
    bus_set(DataA, 1'b0, 8'h00); cyc();
    check("rx_55", bus.mem_din, 8'h55);
    idle();
    tx_ready = 1'b1;
    repeat (5) cyc();
    tx_ready = 1'b0;
    check("tx_partial_head", tx_data, 8'h15);
    check("tx_partial_valid", tx_valid, 1'b1);

    // RX overflow
    for (int i = 0; i < 10; i++) begin
      rx_valid = 1'b1;
      rx_data  = 8'(i);
      check("rx_fill_ready", rx_ready, 32'(i < 8));
      cyc();
    end
    rx_valid = 1'b0;
    check("rx_full_ready", rx_ready, 1'b0);
    bus_set(DataA, 1'b0, 8'h00);
    for (int i = 0; i < 8; i++) begin
      cyc();
      check("rx_drain_data", bus.mem_din, 32'(i));
      if (i == 0) check("rx_ready_after_pop", rx_ready, 1'b1);
    end
    idle();

    // Reset mid-operation; the RAM write issued during reset must not land
    rst = 1'b1;
    bus_set(32'h10, 1'b1, 8'hFF);
    cyc();
    rst = 1'b0;
    idle();
    check("mid_rst_tx_valid", tx_valid, 1'b0);
    check("mid_rst_halt", halt, 1'b0);
    check("mid_rst_din", bus.mem_din, 8'h00);
    check("mid_rst_rx_ready", rx_ready, 1'b1);
    bus_set(32'h10, 1'b0, 8'h00); cyc();
    check("mid_rst_ram_kept", bus.mem_din, 8'hA5);
    idle(); cyc();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
